uart_cmd_parser: RTL and testbench

Byte-stream frame parser that sits directly downstream of the UART receiver. It consumes the receiver's 8-bit data and one-cycle valid strobe, and recognises framed write commands of the form header, address, length, payload, checksum. It buffers the payload and validates the checksum. Only valid frames are replayed as a burst of register writes to the PL register bank, one byte per cycle.

---
 rtl/uart_cmd_parser_if.sv | 23 ++
 rtl/uart_cmd_parser.sv | 218 +++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / register-write-out bundle of the UART command parser.
// The slave modport is the parser side, the master modport the byte source and write sink.
interface uart_cmd_parser_if;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output pi_data, pi_flag,
    input  wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
  );

  modport slave (
    input  pi_data, pi_flag,
    output wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses 55 AA ADDR LEN DATA[LEN] CHK frames from the UART byte stream, buffers the
// payload and replays checksum-valid frames as one register write per cycle.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 500_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  uart_cmd_parser_if.slave bus
);

  localparam int unsigned   AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned   TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR2,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          busy_q, busy_d;

  logic          buf_we_c;
  logic [7:0]    buf_rd_c;
  logic          counting_c;

  // Payload buffer; contents are don't-care until written, so no reset.
  logic [7:0] buf_mem [MAX_LEN];

  always_ff @(posedge sys_clk) begin
    if (buf_we_c) begin
      buf_mem[AW'(idx_q)] <= bus.pi_data;
    end
  end

  assign buf_rd_c = buf_mem[AW'(idx_q)];

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    tmo_d       = '0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we_c    = 1'b0;

    counting_c = (state_q != S_IDLE) && (state_q != S_DRAIN);
    if (counting_c && !bus.pi_flag) begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.pi_flag && (bus.pi_data == 8'h55)) begin
          state_d = S_HDR2;
        end
      end

      // A repeated 0x55 is treated as a fresh first header byte.
      S_HDR2: begin
        if (bus.pi_flag) begin
          if (bus.pi_data == 8'hAA) begin
            state_d = S_ADDR;
          end else if (bus.pi_data != 8'h55) begin
            state_d = S_IDLE;
          end
        end
      end

      S_ADDR: begin
        if (bus.pi_flag) begin
          addr_d  = bus.pi_data;
          sum_d   = bus.pi_data;
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (bus.pi_flag) begin
          if ((bus.pi_data == 8'h00) || (bus.pi_data > MAX_LEN_B)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_BAD_LEN;
            state_d     = S_IDLE;
          end else begin
            len_d   = bus.pi_data;
            sum_d   = sum_q + bus.pi_data;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (bus.pi_flag) begin
          buf_we_c = 1'b1;
          sum_d    = sum_q + bus.pi_data;
          idx_d    = idx_q + 8'd1;
          if (idx_q == (len_q - 8'd1)) begin
            state_d = S_CHK;
          end
        end
      end

      S_CHK: begin
        if (bus.pi_flag) begin
          if (bus.pi_data == sum_q) begin
            idx_d   = '0;
            state_d = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHECKSUM;
            state_d     = S_IDLE;
          end
        end
      end

      // The output register doubles as the buffer's read register.
      S_DRAIN: begin
        if (idx_q == len_q) begin
          frame_ok_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q + idx_q;
          wr_data_d = buf_rd_c;
          idx_d     = idx_q + 8'd1;
        end
        if (bus.pi_flag) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Expiry only when no byte arrives this cycle; a byte always wins.
    if (counting_c && !bus.pi_flag && (tmo_q == TMO_LAST)) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = S_IDLE;
    end

    busy_d = (state_d != S_IDLE) || frame_ok_d;
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: a frame-level reference model with a per-cycle output
// compare, directed frames with literal expectations, then randomized traffic.
module tb_uart_cmd_parser;

  localparam int unsigned MAXL = 16;
  localparam int unsigned TO   = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .MAX_LEN     (MAXL),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pending frame bytes plus an event schedule keyed by cycle.
  byte unsigned fq[$];
  int           last_byte = 0;
  int           dstart    = -10;
  int           dend      = -10;
  logic [15:0]  s_wr  [int];
  bit           s_ok  [int];
  logic [1:0]   s_err [int];

  logic       e_wr_en, e_ok, e_err, e_busy;
  logic [7:0] e_addr, e_data;
  logic [1:0] e_code;
  bit         e_valid = 1'b0;

  // Observed DUT activity for the directed checks.
  logic [15:0] dut_wr[$];
  int          wr_cyc[$];
  int          n_ok = 0, n_err = 0, ok_cyc = -1, err_cyc = -1;
  logic [1:0]  err_cd = 2'd0;
  int          last_strobe = 0;

  byte unsigned fr[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin : model
    int n;
    int s;
    int ln;
    byte unsigned b;
    forever begin
      @(posedge clk);
      n = cyc + 1;
      if (!rst_n) begin
        fq.delete();
        dstart = -10;
        dend   = -10;
        s_wr.delete();
        s_ok.delete();
        s_err.delete();
        e_wr_en = 1'b0; e_addr = 8'h00; e_data = 8'h00;
        e_ok = 1'b0; e_err = 1'b0; e_code = 2'd0; e_busy = 1'b0;
      end else begin
        b = bus.pi_data;
        if (cyc >= dstart && cyc <= dend) begin
          if (bus.pi_flag) s_err[n] = 2'd3;
        end else if (bus.pi_flag) begin
          if (fq.size() == 0) begin
            if (b == 8'h55) fq.push_back(b);
          end else if (fq.size() == 1) begin
            if (b == 8'hAA) fq.push_back(b);
            else if (b != 8'h55) fq.delete();
          end else begin
            fq.push_back(b);
            if (fq.size() == 4 && (b == 8'h00 || int'(b) > int'(MAXL))) begin
              s_err[n] = 2'd1;
              fq.delete();
            end else if (fq.size() >= 5 && fq.size() == 5 + int'(fq[3])) begin
              s = 0;
              for (int i = 2; i < fq.size() - 1; i++) s += int'(fq[i]);
              if ((s % 256) == int'(b)) begin
                ln = int'(fq[3]);
                for (int i = 0; i < ln; i++)
                  s_wr[cyc + 2 + i] = {8'((int'(fq[2]) + i) % 256), fq[4 + i]};
                s_ok[cyc + 2 + ln] = 1'b1;
                dstart = cyc + 1;
                dend   = cyc + 1 + ln;
              end else begin
                s_err[n] = 2'd2;
              end
              fq.delete();
            end
          end
          last_byte = cyc;
        end else if (fq.size() > 0 && (cyc - last_byte) == int'(TO)) begin
          s_err[n] = 2'd0;
          fq.delete();
        end
        e_wr_en = (s_wr.exists(n) != 0);
        if (e_wr_en) begin
          {e_addr, e_data} = s_wr[n];
          s_wr.delete(n);
        end
        e_ok = (s_ok.exists(n) != 0);
        if (e_ok) s_ok.delete(n);
        e_err = (s_err.exists(n) != 0);
        if (e_err) begin
          e_code = s_err[n];
          s_err.delete(n);
        end
        e_busy = (fq.size() > 0) || (n >= dstart && n <= dend + 1);
      end
      e_valid = 1'b1;
      cyc++;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (e_valid) begin
        chk("outputs",
            {10'd0, bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_ok, bus.frame_err,
             bus.err_code, bus.busy},
            {10'd0, e_wr_en, e_addr, e_data, e_ok, e_err, e_code, e_busy});
        if (bus.wr_en === 1'b1) begin
          dut_wr.push_back({bus.wr_addr, bus.wr_data});
          wr_cyc.push_back(cyc);
        end
        if (bus.frame_ok === 1'b1) begin
          n_ok++;
          ok_cyc = cyc;
        end
        if (bus.frame_err === 1'b1) begin
          n_err++;
          err_cyc = cyc;
          err_cd  = bus.err_code;
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send(input byte unsigned b, input int gap);
    bus.pi_data = b;
    bus.pi_flag = 1'b1;
    last_strobe = cyc;
    @(negedge clk);
    bus.pi_flag = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_fr(input int gap, input int last_gap);
    foreach (fr[i]) send(fr[i], (i == fr.size() - 1) ? last_gap : gap);
  endtask

  task automatic mk_frame(input byte unsigned a, input int len, input bit corrupt);
    int s;
    byte unsigned d;
    fr.delete();
    fr.push_back(8'h55);
    fr.push_back(8'hAA);
    fr.push_back(a);
    fr.push_back(8'(len));
    s = int'(a) + len;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom_range(0, 255));
      fr.push_back(d);
      s += int'(d);
    end
    fr.push_back(corrupt ? 8'((s % 256) ^ $urandom_range(1, 255)) : 8'(s % 256));
  endtask

  function automatic logic [15:0] wr_at(input int i);
    return (dut_wr.size() > i) ? dut_wr[i] : 16'hDEAD;
  endfunction

  function automatic int wc_at(input int i);
    return (wr_cyc.size() > i) ? wr_cyc[i] : -1;
  endfunction

  int ok0, err0, s;

  task automatic clr_log();
    dut_wr.delete();
    wr_cyc.delete();
    ok0  = n_ok;
    err0 = n_err;
  endtask

  initial begin : main
    bus.pi_flag = 1'b0;
    bus.pi_data = 8'h00;
    rst_n = 1'b0;
    tick(4);
    chk("reset_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_err_code", {30'd0, bus.err_code}, 32'd0);
    chk("reset_frame_ok", {31'd0, bus.frame_ok}, 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Valid three-byte frame
    clr_log();
    fr = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    send_fr(3, 1);
    s = last_strobe;
    tick(8);
    chk("valid_count", dut_wr.size(), 3);
    chk("valid_w0", wr_at(0), 16'h1001);
    chk("valid_w1", wr_at(1), 16'h1102);
    chk("valid_w2", wr_at(2), 16'h1203);
    chk("valid_first_wr_cycle", wc_at(0), s + 2);
    chk("valid_last_wr_cycle", wc_at(2), s + 4);
    chk("valid_ok_cycle", ok_cyc, s + 5);
    chk("valid_no_err", n_err - err0, 0);

    // Address wrap FE, FF, 00
    clr_log();
    fr = '{8'h55, 8'hAA, 8'hFE, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h22};
    send_fr(3, 1);
    tick(8);
    chk("wrap_w0", wr_at(0), 16'hFE0A);
    chk("wrap_w1", wr_at(1), 16'hFF0B);
    chk("wrap_w2", wr_at(2), 16'h000C);
    chk("wrap_ok", n_ok - ok0, 1);

    // Checksum error, then a good frame
    clr_log();
    fr = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18};
    send_fr(3, 3);
    s = last_strobe;
    tick(6);
    chk("chk_no_writes", dut_wr.size(), 0);
    chk("chk_err_cycle", err_cyc, s + 1);
    chk("chk_err_code", {30'd0, err_cd}, 32'd2);
    fr = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    send_fr(3, 1);
    tick(8);
    chk("chk_then_valid", wr_at(2), 16'h1203);
    chk("chk_then_valid_ok", n_ok - ok0, 1);

    // Length 0 and 17
    clr_log();
    fr = '{8'h55, 8'hAA, 8'h10, 8'h00};
    send_fr(3, 3);
    s = last_strobe;
    tick(3);
    chk("len0_err_cycle", err_cyc, s + 1);
    chk("len0_err_code", {30'd0, err_cd}, 32'd1);
    fr = '{8'h55, 8'hAA, 8'h10, 8'h11};
    send_fr(3, 3);
    s = last_strobe;
    tick(3);
    chk("len17_err_cycle", err_cyc, s + 1);
    chk("len17_err_code", {30'd0, err_cd}, 32'd1);
    chk("len_no_writes", dut_wr.size(), 0);

    // Resync on doubled 0x55
    clr_log();
    fr = '{8'h55, 8'h55, 8'hAA, 8'h20, 8'h01, 8'h7E, 8'h9F};
    send_fr(3, 1);
    tick(6);
    chk("resync_count", dut_wr.size(), 1);
    chk("resync_w0", wr_at(0), 16'h207E);

    // Timeout after the address byte
    clr_log();
    fr = '{8'h55, 8'hAA, 8'h20};
    send_fr(3, 1);
    s = last_strobe;
    tick(int'(TO) + 10);
    chk("tmo_err_cycle", err_cyc, s + int'(TO) + 1);
    chk("tmo_err_code", {30'd0, err_cd}, 32'd0);
    chk("tmo_busy_after", {31'd0, bus.busy}, 32'd0);

    // Reset during the second write of a drain
    clr_log();
    fr = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    send_fr(3, 1);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_wr_addr", {24'd0, bus.wr_addr}, 32'd0);
    rst_n = 1'b1;
    tick(6);
    chk("rst_write_count", dut_wr.size(), 2);
    chk("rst_no_ok", n_ok - ok0, 0);

    // Overrun byte in the middle of a drain
    clr_log();
    fr = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    send_fr(3, 1);
    s = last_strobe;
    tick(1);
    send(8'h77, 1);
    tick(8);
    chk("ovr_count", dut_wr.size(), 3);
    chk("ovr_w2", wr_at(2), 16'h1203);
    chk("ovr_ok", n_ok - ok0, 1);
    chk("ovr_err_cycle", err_cyc, s + 3);
    chk("ovr_err_code", {30'd0, err_cd}, 32'd3);

    // Randomized traffic
    tick(int'(TO) + 5);
    for (int it = 0; it < 200; it++) begin
      int kind, len, gap, k, o;
      byte unsigned a;
      kind = $urandom_range(0, 5);
      a    = 8'($urandom_range(0, 255));
      len  = $urandom_range(1, MAXL);
      gap  = $urandom_range(3, 6);
      case (kind)
        0, 5: begin
          mk_frame(a, len, 1'b0);
          if (kind == 5) fr.push_front(8'h55);
          send_fr(gap, 1);
          if ($urandom_range(0, 3) == 0) begin
            o = $urandom_range(1, len + 1);
            tick(o - 1);
            send(8'($urandom_range(0, 255)), 1);
            tick(len + 4);
          end else begin
            tick(len + 3 + $urandom_range(0, 3));
          end
        end
        1: begin
          mk_frame(a, len, 1'b1);
          send_fr(gap, gap);
        end
        2: begin
          fr = '{8'h55, 8'hAA, a, 8'h00};
          if ($urandom_range(0, 1) == 1) fr[3] = 8'($urandom_range(MAXL + 1, 255));
          send_fr(gap, gap);
        end
        3: begin
          k = $urandom_range(1, 4);
          for (int j = 0; j < k; j++) begin
            case ($urandom_range(0, 3))
              0:       send(8'h55, gap);
              1:       send(8'hAA, gap);
              default: send(8'($urandom_range(0, 255)), gap);
            endcase
          end
          tick(int'(TO) + 5);
        end
        default: begin
          mk_frame(a, len, 1'b0);
          k = $urandom_range(1, 4 + len);
          while (fr.size() > k) void'(fr.pop_back());
          send_fr(gap, gap);
          tick(int'(TO) + 5);
        end
      endcase
    end
    tick(int'(TO) + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
